// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for a fixed-latency multiply/divide unit.
// Launches the unit, counts its latency, commits HI/LO, and stalls EX while busy.
module muldiv_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        unit_start,
  output logic [1:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic [31:0] unit_hi,
  input  logic [31:0] unit_lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd6;
  localparam logic [2:0] OP_MTLO = 3'd7;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   ua_q, ua_d, ub_q, ub_d;
  logic [1:0]    uop_q, uop_d;
  logic          start_q, start_d;

  logic accept, launch_mul, launch_div;

  assign accept     = op_valid && !flush && (state_q == S_IDLE);
  assign launch_mul = accept && (op[2:1] == 2'b00);
  // Divide by zero is swallowed: no launch, HI/LO untouched.
  assign launch_div = accept && (op[2:1] == 2'b01) && (rt_data != 32'd0);

  assign stall      = op_valid && !flush && (state_q == S_RUN);
  assign rd_data    = (op == OP_MFHI) ? hi_q : lo_q;
  assign busy       = (state_q == S_RUN);
  assign unit_start = start_q;
  assign unit_op    = uop_q;
  assign unit_a     = ua_q;
  assign unit_b     = ub_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    uop_d   = uop_q;
    start_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (launch_mul || launch_div) begin
        state_d = S_RUN;
        cnt_d   = launch_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
        ua_d    = rs_data;
        ub_d    = rt_data;
        uop_d   = op[1:0];
        start_d = 1'b1;
      end
      if (accept && op == OP_MTHI) hi_d = rs_data;
      if (accept && op == OP_MTLO) lo_d = rs_data;
    end else begin
      // Flush beats commit even on the final count.
      if (flush) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        hi_d    = unit_hi;
        lo_d    = unit_lo;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ua_q    <= '0;
      ub_q    <= '0;
      uop_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      uop_q   <= uop_d;
      start_q <= start_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed scenarios plus random traffic against a
// transaction-level model that also plays the arithmetic unit.
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, op_valid = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs_data = '0, rt_data = '0, unit_hi = '0, unit_lo = '0;
  logic        stall, busy, unit_start;
  logic [31:0] rd_data, unit_a, unit_b;
  logic [1:0]  unit_op;

  int vectors = 0, miscompares = 0;

  // Reference model: architectural HI/LO, pending unit result, cycles left.
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0, m_rhi = '0, m_rlo = '0;
  logic [1:0]  m_op = '0;
  logic        m_start = 1'b0;
  int          m_left = 0;
  logic        e_stall, e_busy;
  logic [31:0] e_rd;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_data(rs_data),
    .rt_data(rt_data), .flush(flush), .stall(stall), .rd_data(rd_data),
    .busy(busy), .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a),
    .unit_b(unit_b), .unit_hi(unit_hi), .unit_lo(unit_lo)
  );

  // The unit returns garbage except on the cycle the result must be captured.
  task automatic drive(input logic r, input logic v, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
    @(negedge clk);
    rst = r; op_valid = v; op = o; rs_data = a; rt_data = b; flush = fl;
    unit_hi = (m_left == 1) ? m_rhi : $urandom;
    unit_lo = (m_left == 1) ? m_rlo : $urandom;
    e_stall = v && !fl && (m_left > 0);
    e_rd    = (o == 3'd4) ? m_hi : m_lo;
    e_busy  = (m_left > 0);
    #1;
  endtask

  task automatic tick();
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_op = '0; m_start = 1'b0; m_left = 0;
    end else begin
      m_start = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else if (m_left == 1) begin m_hi = m_rhi; m_lo = m_rlo; m_left = 0; end
        else m_left = m_left - 1;
      end else if (op_valid && !flush) begin
        if (op <= 3'd3 && !(op >= 3'd2 && rt_data == 32'd0)) begin
          m_a = rs_data; m_b = rt_data; m_op = op[1:0]; m_start = 1'b1;
          m_left = (op < 3'd2) ? MUL_LAT : DIV_LAT;
          sa = $signed(rs_data); sb = $signed(rt_data);
          case (op)
            3'd0: begin p = sa * sb; m_rhi = p[63:32]; m_rlo = p[31:0]; end
            3'd1: begin p = {32'd0, rs_data} * {32'd0, rt_data}; m_rhi = p[63:32]; m_rlo = p[31:0]; end
            3'd2: begin p = sa / sb; m_rlo = p[31:0]; p = sa % sb; m_rhi = p[31:0]; end
            default: begin m_rlo = rs_data / rt_data; m_rhi = rs_data % rt_data; end
          endcase
        end else if (op == 3'd6) m_hi = rs_data;
        else if (op == 3'd7) m_lo = rs_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 3'd0, 32'h5, 32'h6, 0); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (unit_start !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b want 0", unit_start); end
    vectors++; if ({unit_op, unit_a, unit_b} !== 66'd0) begin miscompares++; $display("FAIL reset_unit: got %h %h %h want 0", unit_op, unit_a, unit_b); end
    drive(0, 1, 3'd4, 0, 0, 0);
    vectors++; if (rd_data !== 32'd0 || stall !== 1'b0) begin miscompares++; $display("FAIL reset_mfhi: got %h stall %b want 0", rd_data, stall); end
    tick();
    drive(0, 1, 3'd5, 0, 0, 0);
    vectors++; if (rd_data !== 32'd0 || stall !== 1'b0) begin miscompares++; $display("FAIL reset_mflo: got %h stall %b want 0", rd_data, stall); end
    tick();
  endtask

  task automatic test_mt_mf();
    drive(0, 1, 3'd6, 32'h1234, 0, 0);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mthi_stall: got %b want 0", stall); end
    tick();
    drive(0, 1, 3'd7, 32'hABCD, 0, 0); tick();
    drive(0, 1, 3'd4, 0, 0, 0);
    vectors++; if (rd_data !== 32'h1234 || stall !== 1'b0) begin miscompares++; $display("FAIL mfhi: got %h want 00001234", rd_data); end
    tick();
    drive(0, 1, 3'd5, 0, 0, 0);
    vectors++; if (rd_data !== 32'hABCD) begin miscompares++; $display("FAIL mflo: got %h want 0000abcd", rd_data); end
    tick();
  endtask

  task automatic test_mult();
    int stalls, starts;
    stalls = 0; starts = 0;
    drive(0, 1, 3'd0, 32'hFFFF_FFFD, 32'd7, 0); tick();
    if (unit_start) starts++;
    vectors++; if (unit_a !== 32'hFFFF_FFFD || unit_b !== 32'd7 || unit_op !== 2'd0) begin miscompares++; $display("FAIL mult_launch: got %h %h %h", unit_op, unit_a, unit_b); end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 3'd5, 0, 0, 0);
      vectors++; if (stall !== e_stall) begin miscompares++; $display("FAIL mult_stall: got %b want %b", stall, e_stall); end
      if (!stall) break;
      stalls++;
      tick();
      if (unit_start) starts++;
    end
    vectors++; if (stalls !== 4) begin miscompares++; $display("FAIL mult_stall_cycles: got %0d want 4", stalls); end
    vectors++; if (starts !== 1) begin miscompares++; $display("FAIL mult_start_pulses: got %0d want 1", starts); end
    vectors++; if (rd_data !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_lo: got %h want ffffffeb", rd_data); end
    tick();
    drive(0, 1, 3'd4, 0, 0, 0);
    vectors++; if (rd_data !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi: got %h want ffffffff", rd_data); end
    tick();
  endtask

  task automatic test_div();
    int bcyc;
    bcyc = 0;
    drive(0, 1, 3'd3, 32'd100, 32'd7, 0); tick();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      bcyc++;
      drive(0, 0, 3'd0, 0, 0, 0); tick();
    end
    vectors++; if (bcyc !== 32) begin miscompares++; $display("FAIL divu_busy_cycles: got %0d want 32", bcyc); end
    drive(0, 1, 3'd4, 0, 0, 0);
    vectors++; if (rd_data !== 32'd2) begin miscompares++; $display("FAIL divu_hi: got %h want 2", rd_data); end
    tick();
    drive(0, 1, 3'd5, 0, 0, 0);
    vectors++; if (rd_data !== 32'd14) begin miscompares++; $display("FAIL divu_lo: got %h want 14", rd_data); end
    tick();
    drive(0, 1, 3'd2, 32'd55, 32'd0, 0); tick();
    vectors++; if (busy !== 1'b0 || unit_start !== 1'b0) begin miscompares++; $display("FAIL div0_launch: busy %b start %b want 0 0", busy, unit_start); end
    drive(0, 1, 3'd5, 0, 0, 0);
    vectors++; if (rd_data !== 32'd14 || stall !== 1'b0) begin miscompares++; $display("FAIL div0_lo: got %h want 14", rd_data); end
    tick();
  endtask

  task automatic test_flush();
    drive(0, 1, 3'd6, 32'h11, 0, 0); tick();
    drive(0, 1, 3'd7, 32'h22, 0, 0); tick();
    drive(0, 1, 3'd0, 32'd5, 32'd6, 0); tick();
    drive(0, 0, 3'd0, 0, 0, 0); tick();
    drive(0, 1, 3'd5, 0, 0, 1);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy: got %b want 0", busy); end
    drive(0, 1, 3'd5, 0, 0, 0);
    vectors++; if (rd_data !== 32'h22) begin miscompares++; $display("FAIL flush_lo: got %h want 22", rd_data); end
    tick();
    drive(0, 1, 3'd0, 32'd5, 32'd6, 0); tick();
    for (int i = 0; i < MUL_LAT - 1; i++) begin drive(0, 0, 3'd0, 0, 0, 0); tick(); end
    drive(0, 0, 3'd0, 0, 0, 1); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_commit_busy: got %b want 0", busy); end
    drive(0, 1, 3'd4, 0, 0, 0);
    vectors++; if (rd_data !== 32'h11) begin miscompares++; $display("FAIL flush_commit_hi: got %h want 11", rd_data); end
    tick();
    drive(0, 1, 3'd5, 0, 0, 0);
    vectors++; if (rd_data !== 32'h22) begin miscompares++; $display("FAIL flush_commit_lo: got %h want 22", rd_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    drive(0, 1, 3'd1, 32'h0001_0000, 32'h0001_0000, 0); tick();
    drive(0, 1, 3'd7, 32'd5, 0, 0);
    while (stall && n < 10) begin tick(); n++; drive(0, 1, 3'd7, 32'd5, 0, 0); end
    vectors++; if (n !== MUL_LAT) begin miscompares++; $display("FAIL mtlo_stall_cycles: got %0d want %0d", n, MUL_LAT); end
    tick();
    drive(0, 1, 3'd5, 0, 0, 0);
    vectors++; if (rd_data !== 32'd5) begin miscompares++; $display("FAIL mtlo_after_commit: got %h want 5", rd_data); end
    tick();
    drive(0, 1, 3'd4, 0, 0, 0);
    vectors++; if (rd_data !== 32'd1) begin miscompares++; $display("FAIL multu_hi: got %h want 1", rd_data); end
    tick();
    drive(0, 1, 3'd3, 32'd1000, 32'd3, 0); tick();
    drive(0, 0, 3'd0, 0, 0, 0); tick();
    drive(1, 1, 3'd6, 32'h77, 0, 0); tick();
    vectors++; if ({busy, unit_start, unit_op, unit_a, unit_b} !== 68'd0) begin miscompares++; $display("FAIL rst_mid_run: got %b %b %h %h %h want 0", busy, unit_start, unit_op, unit_a, unit_b); end
    drive(0, 1, 3'd4, 0, 0, 0);
    vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL rst_mid_hi: got %h want 0", rd_data); end
    tick();
  endtask

  task automatic test_random();
    logic r, v, fl;
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom % 300) == 0;
      v  = $urandom % 2;
      o  = 3'($urandom % 8);
      a  = $urandom;
      b  = (($urandom % 8) == 0) ? 32'd0 : $urandom;
      fl = ($urandom % 12) == 0;
      drive(r, v, o, a, b, fl);
      vectors++; if (stall !== e_stall) begin miscompares++; $display("FAIL rnd_stall @%0d: got %b want %b", i, stall, e_stall); end
      vectors++; if (rd_data !== e_rd) begin miscompares++; $display("FAIL rnd_rd @%0d: got %h want %h", i, rd_data, e_rd); end
      vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, e_busy); end
      tick();
      vectors++; if (unit_start !== m_start) begin miscompares++; $display("FAIL rnd_start @%0d: got %b want %b", i, unit_start, m_start); end
      vectors++; if ({unit_op, unit_a, unit_b} !== {m_op, m_a, m_b}) begin miscompares++; $display("FAIL rnd_unit @%0d: got %h %h %h want %h %h %h", i, unit_op, unit_a, unit_b, m_op, m_a, m_b); end
    end
  endtask

  initial begin
    test_reset();
    test_mt_mf();
    test_mult();
    test_div();
    test_flush();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
